// File: rtl/busy_table_if.sv
`default_nettype none
// ============================================================================
// Module      : busy_table_if
// Description : Dispatch / writeback bundle between rename, execute writeback
//               and the busy_table scoreboard.
//               master : rename + writeback side (drives dispatch, wb, reads
//                        back the per-source busy state)
//               slave  : busy_table
//               Signals:
//                 disp_valid, disp_need_to_wb, disp_prd   - producer dispatch
//                 disp_src{1,2}_is_reg, disp_prs{1,2}     - source lookups
//                 disp_src{1,2}_state                     - 1 = busy, 0 = ready
//                 wb_valid[WB_PORTS], wb_prd (packed, port 0 in LSBs)
// Revision    : 1.0 - initial release
// ============================================================================
interface busy_table_if #(
  parameter int PREG_W   = 6,
  parameter int WB_PORTS = 2
);
  logic                       disp_valid;
  logic                       disp_need_to_wb;
  logic [PREG_W-1:0]          disp_prd;
  logic                       disp_src1_is_reg;
  logic                       disp_src2_is_reg;
  logic [PREG_W-1:0]          disp_prs1;
  logic [PREG_W-1:0]          disp_prs2;
  logic                       disp_src1_state;
  logic                       disp_src2_state;
  logic [WB_PORTS-1:0]        wb_valid;
  logic [WB_PORTS*PREG_W-1:0] wb_prd;

  modport master (
    output disp_valid, disp_need_to_wb, disp_prd,
    output disp_src1_is_reg, disp_src2_is_reg, disp_prs1, disp_prs2,
    output wb_valid, wb_prd,
    input  disp_src1_state, disp_src2_state
  );

  modport slave (
    input  disp_valid, disp_need_to_wb, disp_prd,
    input  disp_src1_is_reg, disp_src2_is_reg, disp_prs1, disp_prs2,
    input  wb_valid, wb_prd,
    output disp_src1_state, disp_src2_state
  );
endinterface
`default_nettype wire

// File: rtl/busy_table.sv
`default_nettype none
// ============================================================================
// Module      : busy_table
// Description : Physical-register ready scoreboard between rename and the
//               issue queue. A preg goes busy when its producer dispatches and
//               ready again when a writeback port reports it. Source lookups
//               are combinational with a same-cycle writeback bypass.
//               Ports:
//                 clock        - system clock
//                 reset_n      - synchronous active-low reset
//                 bus          - dispatch / writeback bundle (slave side)
//                 flush_valid  - pipeline flush, clears every busy bit
//                 busy_count   - registered number of busy pregs
// Revision    : 1.0 - initial release
// ============================================================================
module busy_table #(
  parameter int PREG_NUM = 64,
  parameter int PREG_W   = 6,
  parameter int WB_PORTS = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  busy_table_if.slave       bus,
  input  logic              flush_valid,
  output logic [PREG_W:0]   busy_count
);

  logic [PREG_NUM-1:0] r_busy;

  logic [PREG_NUM-1:0] w_clr;
  logic [PREG_NUM-1:0] w_set;
  logic [PREG_NUM-1:0] w_busy_next;
  logic [PREG_NUM-1:0] w_rise;
  logic [PREG_NUM-1:0] w_fall;
  logic [PREG_W:0]     w_n_rise;
  logic [PREG_W:0]     w_n_fall;
  logic [PREG_W:0]     w_count_next;
  logic                w_hit1;
  logic                w_hit2;
  logic [PREG_W-1:0]   w_port_prd;

  always_comb begin
    w_clr      = '0;
    w_hit1     = 1'b0;
    w_hit2     = 1'b0;
    w_port_prd = '0;
    for (int i = 0; i < WB_PORTS; i++) begin
      w_port_prd = bus.wb_prd[i*PREG_W +: PREG_W];
      if (bus.wb_valid[i]) begin
        // Duplicate ports naming one preg simply set the same clear bit.
        w_clr[w_port_prd] = 1'b1;
        if (w_port_prd == bus.disp_prs1) w_hit1 = 1'b1;
        if (w_port_prd == bus.disp_prs2) w_hit2 = 1'b1;
      end
    end

    w_set = '0;
    if (bus.disp_valid && bus.disp_need_to_wb && (bus.disp_prd != '0)) begin
      w_set[bus.disp_prd] = 1'b1;
    end

    // Set is applied after clear so a new producer wins over a stale
    // writeback of the same preg; flush overrides both.
    if (flush_valid) begin
      w_busy_next = '0;
    end else begin
      w_busy_next = (r_busy & ~w_clr) | w_set;
    end
    w_busy_next[0] = 1'b0;

    // Only real bit transitions move the count, which makes set/clear
    // collisions and writebacks to ready pregs count-neutral.
    w_rise   = w_busy_next & ~r_busy;
    w_fall   = r_busy & ~w_busy_next;
    w_n_rise = '0;
    w_n_fall = '0;
    for (int j = 0; j < PREG_NUM; j++) begin
      w_n_rise = w_n_rise + {{PREG_W{1'b0}}, w_rise[j]};
      w_n_fall = w_n_fall + {{PREG_W{1'b0}}, w_fall[j]};
    end

    if (flush_valid) begin
      w_count_next = '0;
    end else begin
      w_count_next = busy_count + w_n_rise - w_n_fall;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_busy     <= '0;
      busy_count <= '0;
    end else begin
      r_busy     <= w_busy_next;
      busy_count <= w_count_next;
    end
  end

  // Lookups see only older producers (the same-cycle dispatch set is not
  // visible) but do see same-cycle writebacks through the bypass term.
  assign bus.disp_src1_state = reset_n & bus.disp_src1_is_reg &
                               (bus.disp_prs1 != '0) & r_busy[bus.disp_prs1] & ~w_hit1;
  assign bus.disp_src2_state = reset_n & bus.disp_src2_is_reg &
                               (bus.disp_prs2 != '0) & r_busy[bus.disp_prs2] & ~w_hit2;

endmodule
`default_nettype wire

// File: tb/tb_busy_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_busy_table
// Description : Self-checking bench for busy_table. Directed scenarios
//               followed by randomized traffic, all compared against a
//               per-preg busy array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_busy_table;
  localparam int PREG_NUM = 64;
  localparam int PREG_W   = 6;
  localparam int WB_PORTS = 2;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            flush_valid;
  logic [PREG_W:0] busy_count;

  always #5 clock = ~clock;

  busy_table_if #(.PREG_W(PREG_W), .WB_PORTS(WB_PORTS)) bus ();

  busy_table #(
    .PREG_NUM (PREG_NUM),
    .PREG_W   (PREG_W),
    .WB_PORTS (WB_PORTS)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .flush_valid (flush_valid),
    .busy_count  (busy_count)
  );

  bit mdl_busy [PREG_NUM];
  int compared   = 0;
  int mismatched = 0;

  function automatic logic [PREG_W-1:0] port_prd(input int i);
    logic [WB_PORTS*PREG_W-1:0] v;
    v = bus.wb_prd;
    return v[i*PREG_W +: PREG_W];
  endfunction

  function automatic logic mdl_state(input logic is_reg, input logic [PREG_W-1:0] p);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < WB_PORTS; i++)
      if (bus.wb_valid[i] && port_prd(i) == p) hit = 1'b1;
    return reset_n && is_reg && (p != 0) && mdl_busy[p] && !hit;
  endfunction

  function automatic int mdl_count();
    int n;
    n = 0;
    for (int i = 0; i < PREG_NUM; i++) n += int'(mdl_busy[i]);
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance one clock and update the model
  // from the inputs that were sampled at that edge.
  task automatic step(input string tag);
    #3;
    check({tag, "_s1"}, {31'b0, bus.disp_src1_state}, {31'b0, mdl_state(bus.disp_src1_is_reg, bus.disp_prs1)});
    check({tag, "_s2"}, {31'b0, bus.disp_src2_state}, {31'b0, mdl_state(bus.disp_src2_is_reg, bus.disp_prs2)});
    check({tag, "_cnt"}, {25'b0, busy_count}, mdl_count());
    @(posedge clock);
    if (!reset_n || flush_valid) begin
      for (int i = 0; i < PREG_NUM; i++) mdl_busy[i] = 1'b0;
    end else begin
      for (int i = 0; i < WB_PORTS; i++)
        if (bus.wb_valid[i]) mdl_busy[port_prd(i)] = 1'b0;
      if (bus.disp_valid && bus.disp_need_to_wb && bus.disp_prd != 0)
        mdl_busy[bus.disp_prd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    reset_n              = 1'b1;
    flush_valid          = 1'b0;
    bus.disp_valid       = 1'b0;
    bus.disp_need_to_wb  = 1'b0;
    bus.disp_prd         = '0;
    bus.disp_src1_is_reg = 1'b0;
    bus.disp_src2_is_reg = 1'b0;
    bus.disp_prs1        = '0;
    bus.disp_prs2        = '0;
    bus.wb_valid         = '0;
    bus.wb_prd           = '0;
  endtask

  task automatic disp(input logic [PREG_W-1:0] p, input logic need);
    bus.disp_valid      = 1'b1;
    bus.disp_need_to_wb = need;
    bus.disp_prd        = p;
  endtask

  task automatic rd(input logic [PREG_W-1:0] a, input logic [PREG_W-1:0] b);
    bus.disp_src1_is_reg = 1'b1;
    bus.disp_src2_is_reg = 1'b1;
    bus.disp_prs1        = a;
    bus.disp_prs2        = b;
  endtask

  task automatic wb(input int port, input logic [PREG_W-1:0] p);
    bus.wb_valid[port]                 = 1'b1;
    bus.wb_prd[port*PREG_W +: PREG_W]  = p;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    @(posedge clock); #1;
    step("rst0");
    step("rst1");

    idle(); rd(5, 0);            step("after_rst");

    idle(); disp(7, 1);          step("disp7");
    idle(); rd(7, 0);            step("rd7_busy");
    idle(); rd(7, 0); wb(0, 7);  step("wb7_bypass");
    idle(); rd(7, 7);            step("wb7_cleared");

    idle(); disp(9, 1);          step("disp9");
    idle(); disp(9, 1); wb(1, 9); rd(9, 9); step("collide9");
    idle(); rd(9, 0);            step("rd9_still_busy");
    idle(); wb(0, 9);            step("clr9");

    idle(); disp(0, 1);          step("disp0");
    idle(); rd(0, 0);            step("rd0");
    idle(); disp(12, 0);         step("disp12_nowb");
    idle(); rd(12, 12);          step("rd12");

    idle(); disp(3, 1);          step("set3");
    idle(); disp(4, 1);          step("set4");
    idle(); disp(63, 1);         step("set63");
    idle(); rd(63, 4);           step("cnt3");
    idle(); wb(0, 4); wb(1, 4);  step("dup_wb4");
    idle(); rd(4, 3);            step("cnt2");
    idle(); wb(0, 20);           step("wb20_ready");
    idle(); rd(20, 63);          step("cnt2_again");
    idle(); flush_valid = 1'b1; disp(30, 1); step("flush");
    idle(); rd(30, 3);           step("after_flush");

    idle(); disp(10, 1);         step("set10");
    idle(); disp(11, 1);         step("set11");
    idle(); rd(10, 11);          step("cnt_10_11");
    idle(); reset_n = 1'b0; wb(0, 10); rd(11, 11); bus.disp_src1_is_reg = 1'b0; step("mid_reset");
    idle(); rd(11, 10); bus.disp_src1_is_reg = 1'b0; step("after_mid_reset");

    for (int n = 0; n < 400; n++) begin
      idle();
      reset_n              = ($urandom_range(0, 99) != 0);
      flush_valid          = ($urandom_range(0, 49) == 0);
      bus.disp_valid       = $urandom_range(0, 3) != 0;
      bus.disp_need_to_wb  = $urandom_range(0, 4) != 0;
      bus.disp_prd         = PREG_W'($urandom_range(0, PREG_NUM - 1));
      bus.disp_src1_is_reg = $urandom_range(0, 3) != 0;
      bus.disp_src2_is_reg = $urandom_range(0, 3) != 0;
      bus.disp_prs1        = PREG_W'($urandom_range(0, PREG_NUM - 1));
      bus.disp_prs2        = PREG_W'($urandom_range(0, PREG_NUM - 1));
      // Keep the preg space small at times so hits and collisions are common.
      if ($urandom_range(0, 1) == 1) begin
        bus.disp_prd  = PREG_W'($urandom_range(0, 7));
        bus.disp_prs1 = PREG_W'($urandom_range(0, 7));
        bus.disp_prs2 = PREG_W'($urandom_range(0, 7));
      end
      for (int p = 0; p < WB_PORTS; p++)
        if ($urandom_range(0, 1) == 1)
          wb(p, (bus.disp_prd < 8) ? PREG_W'($urandom_range(0, 7))
                                   : PREG_W'($urandom_range(0, PREG_NUM - 1)));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
